// File: rtl/instr_mem_responder.sv
// Word-organized instruction memory answering a req/gnt/rvalid fetch bus.
// Reads happen at grant and travel down a LATENCY-deep response pipeline;
// an outstanding counter throttles grants. A backdoor port loads programs.
module instr_mem_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          DEPTH_WORDS     = 1024,
  parameter int          LATENCY         = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        gnt_stall_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_addr_i,
  input  logic [31:0] wr_data_i
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } resp_t;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      rd_offset;
  logic [31:0]      wr_offset;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_err;
  logic             wr_in_range;
  logic [1:0]       wr_byte_unused;
  resp_t            rd_resp;
  logic [CNT_W-1:0] cnt;

  // Decode fetch and backdoor addresses relative to BASE_ADDR (32-bit wrap).
  always_comb begin
    rd_offset      = instr_addr_i - BASE_ADDR;
    rd_err         = (rd_offset[1:0] != 2'b00) || ((rd_offset >> (IDX_W + 2)) != 32'd0);
    rd_idx         = rd_offset[IDX_W+1:2];
    wr_offset      = wr_addr_i - BASE_ADDR;
    wr_in_range    = (wr_offset >> (IDX_W + 2)) == 32'd0;
    wr_idx         = wr_offset[IDX_W+1:2];
    wr_byte_unused = wr_offset[1:0];
  end

  // Build the response for a grant this cycle; errors never touch the memory.
  always_comb begin
    // NOTE: every field gets a default first so no path leaves a latch behind.
    rd_resp       = '0;
    rd_resp.valid = instr_gnt_o;
    rd_resp.err   = instr_gnt_o & rd_err;
    if (instr_gnt_o && !rd_err) begin
      rd_resp.data = mem[rd_idx];
    end
  end

  // Backdoor write; a same-cycle read has already sampled the old word.
  // NOTE: the memory array is deliberately left out of reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i && wr_in_range) begin
      mem[wr_idx] <= wr_data_i;
    end
  end

  if (LATENCY == 0) begin : g_comb
    // Zero latency: grant and answer in the same cycle, nothing outstanding.
    always_comb begin
      instr_gnt_o    = instr_req_i & ~gnt_stall_i & ~rst;
      instr_rvalid_o = rd_resp.valid;
      instr_err_o    = rd_resp.err;
      instr_rdata_o  = rd_resp.data;
    end

    assign cnt = '0;
  end else begin : g_pipe
    resp_t stage [LATENCY];
    logic  retire;

    assign retire = stage[LATENCY-1].valid;

    // Grant while below the outstanding limit, or when a slot frees this cycle.
    always_comb begin
      instr_gnt_o    = instr_req_i & ~gnt_stall_i & ~rst &
                       ((cnt < CNT_W'(MAX_OUTSTANDING)) | retire);
      instr_rvalid_o = stage[LATENCY-1].valid;
      instr_err_o    = stage[LATENCY-1].err;
      instr_rdata_o  = stage[LATENCY-1].data;
    end

    // Shift responses toward the output; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) begin
          stage[i] <= '0;
        end
      end else begin
        // NOTE: non-blocking updates let each stage take its neighbour's old value.
        stage[0] <= rd_resp;
        for (int i = 1; i < LATENCY; i++) begin
          stage[i] <= stage[i-1];
        end
      end
    end

    // Track granted-but-unanswered requests; grant and retire together cancel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt <= '0;
      end else if (instr_gnt_o && !retire) begin
        cnt <= cnt + CNT_W'(1);
      end else if (!instr_gnt_o && retire) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Self-checking bench for instr_mem_responder. Four differently configured
// instances each run directed and random fetch traffic; a per-instance
// reference model predicts grants and queues expected responses with their
// due cycle, and a monitor compares every cycle at the falling edge.
module tb_instr_mem_responder;

  localparam int NCFG = 4;

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } exp_t;

  logic clk;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   n_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input int cfg, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL cfg%0d %s: actual %h required %h at %0t", cfg, name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int          LAT   = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 0 : 2;
    localparam int          MAXO  = (g == 2) ? 1 : 2;
    localparam logic [31:0] BASE  = (g == 2) ? 32'hFFFF_FFF0 : (g == 3) ? 32'h0000_1000 : 32'h0;
    localparam int          DEPTH = (g == 2) ? 4 : 16;

    logic        rst, req, stall, wr_en;
    logic [31:0] addr, wr_addr, wr_data;
    logic        gnt, rvalid, err;
    logic [31:0] rdata;

    logic [31:0] mm [int];
    exp_t        q [$];
    int          cyc = 0;

    instr_mem_responder #(
      .BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
    ) u_dut (
      .clk(clk), .rst(rst),
      .instr_req_i(req), .instr_addr_i(addr),
      .instr_gnt_o(gnt), .instr_rvalid_o(rvalid),
      .instr_rdata_o(rdata), .instr_err_o(err),
      .gnt_stall_i(stall),
      .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data)
    );

    // A fetch address is good when word aligned and inside the window.
    function automatic logic addr_ok(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (off % 4 == 0) && (off / 4 < 32'(DEPTH));
    endfunction

    // Backdoor writes ignore the byte offset.
    function automatic logic wr_ok(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return off / 4 < 32'(DEPTH);
    endfunction

    function automatic int word_of(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return int'(off / 4);
    endfunction

    // Monitor and reference model: predict grant, queue responses, compare.
    always @(negedge clk) begin
      logic eg, due_now;
      exp_t e;
      if (rst) begin
        q.delete();
        check(g, "gnt_in_reset", 32'(gnt), 32'h0);
        check(g, "rvalid_in_reset", 32'(rvalid), 32'h0);
        check(g, "rdata_in_reset", rdata, 32'h0);
        check(g, "err_in_reset", 32'(err), 32'h0);
      end else begin
        due_now = (q.size() > 0) && (q[0].due == cyc);
        eg = req && !stall && (LAT == 0 || q.size() < MAXO || due_now);
        check(g, "outstanding", 32'(u_dut.cnt), 32'(q.size()));
        check(g, "gnt", 32'(gnt), 32'(eg));
        if (eg) begin
          e.due  = cyc + LAT;
          e.err  = !addr_ok(addr);
          e.data = e.err ? 32'h0 : mm[word_of(addr)];
          q.push_back(e);
        end
        if (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          check(g, "rvalid", 32'(rvalid), 32'h1);
          check(g, "rdata", rdata, e.data);
          check(g, "err", 32'(err), 32'(e.err));
        end else begin
          check(g, "rvalid_idle", 32'(rvalid), 32'h0);
          check(g, "rdata_idle", rdata, 32'h0);
          check(g, "err_idle", 32'(err), 32'h0);
        end
        if (wr_en && wr_ok(wr_addr)) begin
          mm[word_of(wr_addr)] = wr_data;
        end
      end
      cyc++;
    end

    task automatic drive(input logic r, input logic [31:0] a, input logic s);
      req = r; addr = a; stall = s;
      @(posedge clk); #1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
      req = 1'b0; wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(posedge clk); #1;
      wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, BASE, 1'b0);
    endtask

    // Stimulus: program load, directed scenarios, random traffic, reset.
    initial begin
      logic [31:0] prog [4];
      logic [31:0] a;
      int          ci;
      prog = '{32'h0000_0013, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193};
      rst = 1'b1; req = 1'b0; stall = 1'b0; addr = BASE;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      for (int i = 0; i < DEPTH; i++) begin
        load(BASE + 32'(4 * i), (i < 4) ? prog[i] : (i == 4) ? 32'h0000_0013 : $urandom());
      end
      load(BASE + 32'(4 * DEPTH), 32'hBAD0_BAD0);
      idle(2);

      // Back-to-back fetch of the first four words.
      for (int i = 0; i < 4; i++) drive(1'b1, BASE + 32'(4 * i), 1'b0);
      idle(LAT + 2);

      // Misaligned and out-of-range requests mixed with good ones.
      drive(1'b1, BASE + 32'h2, 1'b0);
      drive(1'b1, BASE + 32'(4 * DEPTH), 1'b0);
      drive(1'b1, BASE + 32'h4, 1'b0);
      drive(1'b1, BASE + 32'(4 * DEPTH - 4), 1'b0);
      idle(LAT + 2);

      // Stall with responses in flight, then release.
      drive(1'b1, BASE, 1'b0);
      drive(1'b1, BASE + 32'h8, 1'b0);
      repeat (5) drive(1'b1, BASE + 32'hC, 1'b1);
      drive(1'b1, BASE + 32'hC, 1'b0);
      idle(LAT + 2);

      // Read and backdoor write of the same word in one cycle.
      ci = (DEPTH > 4) ? 4 : 2;
      req = 1'b1; addr = BASE + 32'(4 * ci); stall = 1'b0;
      wr_en = 1'b1; wr_addr = addr; wr_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      wr_en = 1'b0;
      drive(1'b1, BASE + 32'(4 * ci), 1'b0);
      idle(LAT + 2);

      // Random traffic with occasional stalls and backdoor writes.
      for (int n = 0; n < 400; n++) begin
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0)      a = $urandom();
        else if (k == 1) a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(1, 3));
        else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
        wr_en   = ($urandom_range(0, 7) == 0);
        wr_addr = ($urandom_range(0, 5) == 0) ? $urandom()
                : BASE + 32'(4 * $urandom_range(0, DEPTH - 1)) + 32'($urandom_range(0, 3));
        wr_data = $urandom();
        drive($urandom_range(0, 3) != 0, a, $urandom_range(0, 7) == 0);
      end
      wr_en = 1'b0;
      idle(LAT + 2);

      // Reset with two fetches in flight; nothing may come out afterwards.
      drive(1'b1, BASE, 1'b0);
      drive(1'b1, BASE + 32'h4, 1'b0);
      rst = 1'b1; req = 1'b1; addr = BASE + 32'h8;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      idle(6);
      drive(1'b1, BASE + 32'hC, 1'b0);
      idle(LAT + 2);
      check(g, "scoreboard_drained", 32'(q.size()), 32'h0);
      n_done++;
    end
  end

  // Wait for every configuration to finish, bounded, then summarise.
  initial begin
    int t;
    t = 0;
    while (n_done < NCFG && t < 20000) begin
      @(posedge clk);
      t++;
    end
    if (n_done < NCFG) check(-1, "run_timeout", 32'(n_done), 32'(NCFG));
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
